rs_decode_scheduler: RTL and testbench

- Shares one RS(15,9) GF(16) decoder instance (60-bit received word in, 36-bit message out, toggle-triggered `decodeMessage`, `decoderBusy` status) between NUM_CH requesters.
- Round-robin arbitration; valid/ready on every request channel and on the single result channel.
- Drives the decoder trigger, enforces a settle window, captures the message and returns it tagged with the requester index.

---
 rtl/rs_decode_scheduler.sv | 172 +++++++++++++++++
 tb/tb_rs_decode_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_decode_scheduler.sv
// Round-robin scheduler sharing one toggle-triggered RS(15,9) decoder among NUM_CH requesters.
// Optional busy timeout abort is compiled in with `define RS_SCHED_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | search for a request from rrPtr upward, grant and latch its word
//   ISSUE   | toggle decTrigger, clear settle counter
//   SETTLE  | wait minimum settle window and decoder busy low (or timeout)
//   CAPTURE | sample decoder message, raise resValid, advance rrPtr
//   DELIVER | hold result until resReady
module rs_decode_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int SETTLE_CYC  = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [NUM_CH-1:0]      reqValid,
  output logic [NUM_CH-1:0]      reqReady,
  input  logic [60*NUM_CH-1:0]   reqWord,
  output logic [59:0]            decWordOut,
  output logic                   decTrigger,
  input  logic                   decBusyIn,
  input  logic [35:0]            decMsgIn,
  output logic                   resValid,
  input  logic                   resReady,
  output logic [35:0]            resMsg,
  output logic [CH_W-1:0]        resCh,
  output logic                   resTimeout,
  output logic                   schedBusy
);

  if (NUM_CH < 2 || NUM_CH > 8) begin : gBadNumCh
    $error("NUM_CH must be 2..8");
  end
  if (CH_W != $clog2(NUM_CH)) begin : gBadChW
    $error("CH_W must equal clog2(NUM_CH)");
  end
  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : gBadSettle
    $error("SETTLE_CYC must be 1..15");
  end
  if (TIMEOUT_CYC < 2) begin : gBadTimeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, CAPTURE, DELIVER} stateT;

  localparam logic [3:0] SettleLast = 4'(SETTLE_CYC - 1);

  stateT            state, stateNxt;
  logic [CH_W-1:0]  rrPtr;
  logic [CH_W-1:0]  grantIdx;
  logic [CH_W-1:0]  candIdx;
  logic             grantHit;
  logic [3:0]       cntr;
  logic             settleDone;
  logic             timedOut;
  logic [35:0]      capMsg;
  logic [59:0]      wordArr [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : gSlice
    assign wordArr[g] = reqWord[60*g +: 60];
  end

  // First valid channel at or after rrPtr, wrapping at NUM_CH-1.
  always_comb begin
    int cand;
    grantHit = 1'b0;
    grantIdx = '0;
    candIdx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = int'(rrPtr) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      candIdx = CH_W'(cand);
      if (!grantHit && reqValid[candIdx]) begin
        grantHit = 1'b1;
        grantIdx = candIdx;
      end
    end
  end

  always_comb begin
    reqReady = '0;
    if (state == IDLE && grantHit) reqReady[grantIdx] = 1'b1;
  end

  assign settleDone = (cntr >= SettleLast) && !decBusyIn;
  assign schedBusy  = (state != IDLE);

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (grantHit) stateNxt = ISSUE;
      ISSUE:   stateNxt = SETTLE;
      SETTLE:  if (settleDone || timedOut) stateNxt = CAPTURE;
      CAPTURE: stateNxt = DELIVER;
      DELIVER: if (resReady) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      rrPtr      <= '0;
      decWordOut <= '0;
      decTrigger <= 1'b0;
      resValid   <= 1'b0;
      resMsg     <= '0;
      resCh      <= '0;
      cntr       <= '0;
    end else begin
      state <= stateNxt;
      case (state)
        IDLE: begin
          if (grantHit) begin
            decWordOut <= wordArr[grantIdx];
            resCh      <= grantIdx;
          end
        end
        ISSUE: begin
          decTrigger <= ~decTrigger;
          cntr       <= '0;
        end
        SETTLE: begin
          // Saturate so an indefinitely busy decoder cannot wrap the window.
          if (cntr != 4'hF) cntr <= cntr + 1'b1;
        end
        CAPTURE: begin
          resMsg   <= capMsg;
          resValid <= 1'b1;
          rrPtr    <= (resCh == CH_W'(NUM_CH - 1)) ? '0 : resCh + 1'b1;
        end
        DELIVER: begin
          if (resReady) resValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef RS_SCHED_TIMEOUT_EN
  localparam int ToW = $clog2(TIMEOUT_CYC);

  logic [ToW-1:0] toCntr;
  logic           toFlag;

  assign timedOut = (state == SETTLE) && decBusyIn && (toCntr == ToW'(TIMEOUT_CYC - 1));
  assign capMsg   = toFlag ? '0 : decMsgIn;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      toCntr     <= '0;
      toFlag     <= 1'b0;
      resTimeout <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        toCntr <= '0;
        toFlag <= 1'b0;
      end else if (state == SETTLE) begin
        if (timedOut)       toFlag <= 1'b1;
        else if (decBusyIn) toCntr <= toCntr + 1'b1;
      end
      if (state == CAPTURE) resTimeout <= toFlag;
    end
  end
`else
  assign timedOut   = 1'b0;
  assign capMsg     = decMsgIn;
  assign resTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_rs_decode_scheduler.sv
// Self-checking bench for rs_decode_scheduler: decoder model, scoreboard, vector table, corner sequences.
// Timeout sequence runs only when RS_SCHED_TIMEOUT_EN is defined.
module tb_rs_decode_scheduler;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic                 clk  = 1'b0;
  logic                 rstN = 1'b1;
  logic [NUM_CH-1:0]    reqValid = '0;
  logic [NUM_CH-1:0]    reqReady;
  logic [60*NUM_CH-1:0] reqWord;
  logic [59:0]          decWordOut;
  logic                 decTrigger;
  logic                 decBusyIn;
  logic [35:0]          decMsgIn;
  logic                 resValid;
  logic                 resReady = 1'b0;
  logic [35:0]          resMsg;
  logic [CH_W-1:0]      resCh;
  logic                 resTimeout;
  logic                 schedBusy;

  int errors = 0;
  int checks = 0;

  logic [59:0] words  [NUM_CH];
  logic [35:0] chMsg  [NUM_CH];
  assign reqWord = {words[3], words[2], words[1], words[0]};

  rs_decode_scheduler #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .SETTLE_CYC(3), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqReady(reqReady), .reqWord(reqWord),
    .decWordOut(decWordOut), .decTrigger(decTrigger),
    .decBusyIn(decBusyIn), .decMsgIn(decMsgIn),
    .resValid(resValid), .resReady(resReady), .resMsg(resMsg),
    .resCh(resCh), .resTimeout(resTimeout), .schedBusy(schedBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decoder model: busy for modelBusyLen cycles after each toggle, garbage message while busy.
  int   modelBusyLen = 0;
  int   busyLeft     = 0;
  logic modelTrig    = 1'b0;
  always @(negedge clk) begin
    if (!rstN) begin
      modelTrig = 1'b0;
      busyLeft  = 0;
    end else if (decTrigger != modelTrig) begin
      modelTrig = decTrigger;
      busyLeft  = modelBusyLen;
    end else if (busyLeft > 0) begin
      busyLeft--;
    end
  end
  assign decBusyIn = (busyLeft > 0);
  assign decMsgIn  = decBusyIn ? 36'hBADBADBAD : decWordOut[59:24];

  typedef struct packed {
    logic [35:0]     msg;
    logic [CH_W-1:0] ch;
    logic            tmo;
  } expT;

  expT  sbQ[$];
  int   grantLog[$];
  logic expectTo   = 1'b0;
  int   toggles    = 0;
  logic lastTrig   = 1'b0;

  always @(negedge clk) begin
    expT e;
    int  gIdx;
    if (rstN) begin
      if (decTrigger !== lastTrig) toggles++;
      if (reqReady !== '0) begin
        checks++;
        if ($countones(reqReady) != 1 || schedBusy) begin
          errors++;
          $display("FAIL rdyLegal: reqReady=%b schedBusy=%b, required one-hot while idle", reqReady, schedBusy);
        end else begin
          gIdx = 0;
          for (int c = 0; c < NUM_CH; c++) if (reqReady[c]) gIdx = c;
          e.msg = expectTo ? 36'h0 : chMsg[gIdx];
          e.ch  = CH_W'(gIdx);
          e.tmo = expectTo;
          sbQ.push_back(e);
          grantLog.push_back(gIdx);
        end
      end
      if (resValid && resReady) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sbEmpty: result ch=%0d msg=%0h with nothing expected", resCh, resMsg);
        end else begin
          e = sbQ.pop_front();
          chk("resMsg", resMsg, e.msg);
          chk("resCh", resCh, e.ch);
          chk("resTimeout", resTimeout, e.tmo);
        end
      end
    end
    lastTrig = decTrigger;
  end

  task automatic setCh(input logic [CH_W-1:0] ch, input logic [35:0] msg);
    chMsg[ch] = msg;
    words[ch] = {msg, 24'hC0FFEE};
  endtask

  task automatic waitReady(input logic [CH_W-1:0] ch, input string tag);
    int n = 0;
    @(negedge clk);
    while (!reqReady[ch] && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s grantWait: reqReady=%b, required bit %0d", tag, reqReady, ch);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sbQ.size() != 0 || schedBusy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s drain: queue=%0d schedBusy=%b, required empty and idle", tag, sbQ.size(), schedBusy);
    end
  endtask

  task automatic runJob(input logic [CH_W-1:0] ch, input logic [35:0] msg,
                        input int busyLen, input int expLat, input string tag);
    int lat;
    int t0;
    @(posedge clk); #1;
    modelBusyLen = busyLen;
    setCh(ch, msg);
    reqValid[ch] = 1'b1;
    resReady     = 1'b1;
    waitReady(ch, tag);
    t0 = toggles;
    @(posedge clk); #1;
    reqValid[ch] = 1'b0;
    lat = 0;
    while (!resValid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, expLat);
    chk({tag, "_toggles"}, toggles - t0, 1);
    @(posedge clk); #1;
    chk({tag, "_idleAfter"}, {resValid, schedBusy}, 2'b00);
  endtask

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [35:0]     msg;
    int              busyLen;
    int              expLat;
  } vecT;

  vecT vecs[6];
  int  rrExp[5];

  initial begin
    int   n;
    logic sawValid;
    int   t0;

    vecs[0] = '{2'd2, 36'h123456789, 0, 5};
    vecs[1] = '{2'd0, 36'hFEDCBA987, 0, 5};
    vecs[2] = '{2'd3, 36'h000000001, 1, 5};
    vecs[3] = '{2'd1, 36'hA5A5A5A5A, 2, 5};
    vecs[4] = '{2'd2, 36'h0F0F0F0F0, 3, 6};
    vecs[5] = '{2'd0, 36'h13579BDF0, 8, 11};
    rrExp   = '{0, 1, 2, 3, 0};
    for (int c = 0; c < NUM_CH; c++) begin
      words[c] = '0;
      chMsg[c] = '0;
    end

    #1 rstN = 1'b0;
    #1;
    chk("rst_reqReady", reqReady, 0);
    chk("rst_decWordOut", decWordOut, 0);
    chk("rst_decTrigger", decTrigger, 0);
    chk("rst_resValid", resValid, 0);
    chk("rst_resMsg", resMsg, 0);
    chk("rst_resCh", resCh, 0);
    chk("rst_resTimeout", resTimeout, 0);
    chk("rst_schedBusy", schedBusy, 0);
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;

    // Round-robin with all channels requesting.
    @(posedge clk); #1;
    for (int c = 0; c < NUM_CH; c++) setCh(CH_W'(c), 36'h100000000 + 36'(c * 17));
    modelBusyLen = 0;
    resReady     = 1'b1;
    grantLog.delete();
    reqValid     = '1;
    n = 0;
    while (grantLog.size() < 5 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    reqValid = '0;
    drain("rr");
    chk("rr_count", grantLog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < grantLog.size()) chk("rr_order", grantLog[i], rrExp[i]);
    end

    // Vector table: single requests, varying decoder busy.
    for (int v = 0; v < 6; v++) runJob(vecs[v].ch, vecs[v].msg, vecs[v].busyLen, vecs[v].expLat, "vec");

    // Backpressure: result held, no grant while DELIVER waits.
    @(posedge clk); #1;
    modelBusyLen = 0;
    resReady     = 1'b0;
    setCh(2'd1, 36'h0DDBA11ED);
    reqValid[1]  = 1'b1;
    waitReady(2'd1, "bp");
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    setCh(2'd2, 36'h2468ACE02);
    reqValid[2] = 1'b1;
    n = 0;
    while (!resValid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (10) begin
      @(negedge clk);
      chk("bp_reqReady", reqReady, 0);
      chk("bp_resValid", resValid, 1);
      chk("bp_resMsg", resMsg, 36'h0DDBA11ED);
      chk("bp_resCh", resCh, 1);
    end
    @(posedge clk); #1;
    resReady = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_nextGrant", reqReady, 4'b0100);
    @(posedge clk); #1;
    reqValid[2] = 1'b0;
    drain("bp");

    // Leave rrPtr at 1, then abandon a ch3 job in SETTLE via reset.
    runJob(2'd0, 36'h55AA55AA5, 0, 5, "pre");
    @(posedge clk); #1;
    modelBusyLen = 20;
    setCh(2'd3, 36'h333333333);
    reqValid[3]  = 1'b1;
    waitReady(2'd3, "rstJob");
    @(posedge clk); #1;
    reqValid[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", schedBusy, 1);
    rstN = 1'b0;
    #1;
    chk("mid_rst_reqReady", reqReady, 0);
    chk("mid_rst_decWordOut", decWordOut, 0);
    chk("mid_rst_decTrigger", decTrigger, 0);
    chk("mid_rst_resValid", resValid, 0);
    chk("mid_rst_resMsg", resMsg, 0);
    chk("mid_rst_resCh", resCh, 0);
    chk("mid_rst_schedBusy", schedBusy, 0);
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    modelBusyLen = 0;
    sawValid = 1'b0;
    t0 = toggles;
    repeat (10) begin
      @(negedge clk);
      if (resValid) sawValid = 1'b1;
    end
    chk("post_rst_noResult", sawValid, 0);
    chk("post_rst_noToggle", toggles - t0, 0);
    chk("post_rst_decTrigger", decTrigger, 0);
    @(posedge clk); #1;
    setCh(2'd0, 36'h0000ABCDE);
    setCh(2'd2, 36'h2222EEEE2);
    reqValid[0] = 1'b1;
    reqValid[2] = 1'b1;
    @(negedge clk);
    chk("post_rst_firstGrant", reqReady, 4'b0001);
    @(posedge clk); #1;
    reqValid[0] = 1'b0;
    waitReady(2'd2, "postRst");
    @(posedge clk); #1;
    reqValid[2] = 1'b0;
    drain("postRst");

`ifdef RS_SCHED_TIMEOUT_EN
    expectTo = 1'b1;
    runJob(2'd1, 36'h777777777, 1000, 66, "timeout");
    expectTo = 1'b0;
    runJob(2'd2, 36'h888888888, 0, 5, "afterTimeout");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
